// File: rtl/vga_sync_gen_if.sv
// ---------------------------------------------------------------------------
// vga_sync_gen_if
//   Bundles the scan-timing outputs of vga_sync_gen together with the camera
//   row input that the generator re-times to vertical blank.
//   Ports (signals):
//     camera_y_in   camera block index from game logic (into the generator)
//     p_tick        one-sys_clk pulse per pixel period
//     x, y          current horizontal / vertical scan position
//     video_on      high inside the visible area
//     hsync, vsync  sync pulses to the VGA connector
//     frame_start   pulse when the scan position becomes (0,0)
//     vblank_start  pulse when y becomes the first blanked line
//     camera_y      frame-stable copy of camera_y_in
//   Modports:
//     master  timing generator side (drives timing, reads camera_y_in)
//     slave   consumer side (pixel generator / game logic)
// ---------------------------------------------------------------------------
interface vga_sync_gen_if #(
  parameter int SCREEN_WIDTH = 10,
  parameter int CAM_WIDTH    = 5
);
  logic [CAM_WIDTH-1:0]    camera_y_in;
  logic                    p_tick;
  logic [SCREEN_WIDTH-1:0] x;
  logic [SCREEN_WIDTH-1:0] y;
  logic                    video_on;
  logic                    hsync;
  logic                    vsync;
  logic                    frame_start;
  logic                    vblank_start;
  logic [CAM_WIDTH-1:0]    camera_y;

  modport master (
    input  camera_y_in,
    output p_tick, x, y, video_on, hsync, vsync,
           frame_start, vblank_start, camera_y
  );

  modport slave (
    output camera_y_in,
    input  p_tick, x, y, video_on, hsync, vsync,
           frame_start, vblank_start, camera_y
  );
endinterface

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   VGA timing source. Divides sys_clk into a pixel tick, runs horizontal and
//   vertical scan counters and produces registered x/y/video_on/hsync/vsync.
//   camera_y_in is sampled only on the edge where the scan enters vertical
//   blank, so scrolled content never changes part-way through a frame.
//
//   Ports:
//     sys_clk    in   system clock (only clock)
//     sys_rst    in   asynchronous, active-high reset
//     frame_cnt  out  [15:0] frame counter (only with VGA_FRAME_CNT_EN)
//     vga        vga_sync_gen_if.master: camera_y_in in; p_tick, x, y,
//                video_on, hsync, vsync, frame_start, vblank_start,
//                camera_y out
//
//   Optional feature macro: VGA_FRAME_CNT_EN
//     defined   -> adds frame_cnt, +1 on every frame_start edge, wraps
//     undefined -> no frame_cnt port, no counter
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_DISPLAY    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_DISPLAY    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int SCREEN_WIDTH = 10,
  parameter int CAM_WIDTH    = 5,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0]    frame_cnt,
`endif
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_WIDTH = $clog2(CLK_DIV);

  localparam logic [DIV_WIDTH-1:0]    DIV_LAST = DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [SCREEN_WIDTH-1:0] H_LAST   = SCREEN_WIDTH'(H_TOTAL - 1);
  localparam logic [SCREEN_WIDTH-1:0] V_LAST   = SCREEN_WIDTH'(V_TOTAL - 1);
  localparam logic [SCREEN_WIDTH-1:0] H_VIS    = SCREEN_WIDTH'(H_DISPLAY);
  localparam logic [SCREEN_WIDTH-1:0] V_VIS    = SCREEN_WIDTH'(V_DISPLAY);
  localparam logic [SCREEN_WIDTH-1:0] HS_BEGIN = SCREEN_WIDTH'(H_DISPLAY + H_FRONT);
  localparam logic [SCREEN_WIDTH-1:0] HS_END   = SCREEN_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [SCREEN_WIDTH-1:0] VS_BEGIN = SCREEN_WIDTH'(V_DISPLAY + V_FRONT);
  localparam logic [SCREEN_WIDTH-1:0] VS_END   = SCREEN_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_WIDTH-1:0]    div_cnt_reg;
  logic                    p_tick_reg;
  logic [SCREEN_WIDTH-1:0] h_cnt_reg;
  logic [SCREEN_WIDTH-1:0] v_cnt_reg;
  logic                    video_on_reg;
  logic                    hsync_reg;
  logic                    vsync_reg;
  logic                    frame_start_reg;
  logic                    vblank_start_reg;
  logic [CAM_WIDTH-1:0]    camera_y_reg;

  logic [SCREEN_WIDTH-1:0] h_next;
  logic [SCREEN_WIDTH-1:0] v_next;
  logic                    video_on_next;
  logic                    hsync_next;
  logic                    vsync_next;
  logic                    frame_next;
  logic                    vblank_next;

  // Next scan position. Every registered output is decoded from these so
  // that x, y, video_on and both syncs move together on the same edge.
  always_comb begin
    h_next = h_cnt_reg;
    v_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_next = '0;
      v_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_next = h_cnt_reg + 1'b1;
    end
    video_on_next = (h_next < H_VIS) && (v_next < V_VIS);
    hsync_next    = ((h_next >= HS_BEGIN) && (h_next < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_next    = ((v_next >= VS_BEGIN) && (v_next < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    frame_next    = (h_next == '0) && (v_next == '0);
    vblank_next   = (h_next == '0) && (v_next == V_VIS);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt_reg      <= '0;
      p_tick_reg       <= 1'b0;
      h_cnt_reg        <= '0;
      v_cnt_reg        <= '0;
      video_on_reg     <= 1'b0;
      hsync_reg        <= ~HSYNC_POL;
      vsync_reg        <= ~VSYNC_POL;
      frame_start_reg  <= 1'b0;
      vblank_start_reg <= 1'b0;
      camera_y_reg     <= '0;
    end else begin
      div_cnt_reg      <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
      p_tick_reg       <= (div_cnt_reg == DIV_LAST);
      // Event strobes last one sys_clk; CLK_DIV >= 2 guarantees p_tick is
      // low on the following cycle.
      frame_start_reg  <= 1'b0;
      vblank_start_reg <= 1'b0;
      if (p_tick_reg) begin
        h_cnt_reg        <= h_next;
        v_cnt_reg        <= v_next;
        video_on_reg     <= video_on_next;
        hsync_reg        <= hsync_next;
        vsync_reg        <= vsync_next;
        frame_start_reg  <= frame_next;
        vblank_start_reg <= vblank_next;
        // Latch the camera row only when blanking begins, so the whole
        // next visible frame uses one consistent scroll value.
        if (vblank_next) begin
          camera_y_reg <= vga.camera_y_in;
        end
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_cnt_reg <= '0;
    end else if (p_tick_reg && frame_next) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

  assign vga.p_tick       = p_tick_reg;
  assign vga.x            = h_cnt_reg;
  assign vga.y            = v_cnt_reg;
  assign vga.video_on     = video_on_reg;
  assign vga.hsync        = hsync_reg;
  assign vga.vsync        = vsync_reg;
  assign vga.frame_start  = frame_start_reg;
  assign vga.vblank_start = vblank_start_reg;
  assign vga.camera_y     = camera_y_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Directed bench for vga_sync_gen using a reduced timing set
//   (H 8/1/2/1 -> 12 pixels per line, V 4/1/1/1 -> 7 lines, CLK_DIV 4) so
//   full frames fit in a short run. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int CLK_DIV = 4;
  localparam int HD = 8, HF = 1, HS = 2, HB = 1;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;   // 12
  localparam int VT = VD + VF + VS + VB;   // 7
  localparam int SW = 10;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vga_sync_gen_if #(.SCREEN_WIDTH(SW), .CAM_WIDTH(CW)) vga ();

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_sync_gen #(
    .CLK_DIV(CLK_DIV),
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SCREEN_WIDTH(SW), .CAM_WIDTH(CW),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .vga(vga)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hm;
    int vm;
    int frame;
    int waited;
    int clk_cnt;
    int last_fs;
    int found;
    logic [CW-1:0] cam_exp;
    logic [15:0]   fc_exp;

    vga.camera_y_in = '0;

    // ---- reset state ----
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_p_tick",   vga.p_tick, 0);
    check("rst_x",        vga.x, 0);
    check("rst_y",        vga.y, 0);
    check("rst_video_on", vga.video_on, 0);
    check("rst_hsync",    vga.hsync, 1);
    check("rst_vsync",    vga.vsync, 1);
    check("rst_frame_st", vga.frame_start, 0);
    check("rst_vblank",   vga.vblank_start, 0);
    check("rst_camera_y", vga.camera_y, 0);
`ifdef VGA_FRAME_CNT_EN
    check("rst_frame_cnt", frame_cnt, 0);
`endif

    // ---- first ticks: p_tick after 4 edges, x moves on the 5th ----
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("p_tick_phase", vga.p_tick, (k % 4 == 0) ? 1 : 0);
      check("x_first_adv",  vga.x, (k >= 5) ? 1 : 0);
    end

    // ---- two-plus frames of pixel-by-pixel checking ----
    hm = 1; vm = 0; frame = 0;
    cam_exp = '0; fc_exp = '0;
    clk_cnt = 8; last_fs = -1;
    for (int p = 0; p < 200; p++) begin
      // here p_tick is high; the next edge advances the scan
      @(negedge clk);
      clk_cnt++;
      if (hm == HT - 1) begin
        hm = 0;
        vm = (vm == VT - 1) ? 0 : vm + 1;
      end else begin
        hm = hm + 1;
      end
      if (hm == 0 && vm == VD) cam_exp = vga.camera_y_in;
      if (hm == 0 && vm == 0) begin
        fc_exp = fc_exp + 16'd1;
        frame++;
      end

      check("x",            vga.x, hm);
      check("y",            vga.y, vm);
      check("video_on",     vga.video_on, (hm < HD && vm < VD) ? 1 : 0);
      check("hsync",        vga.hsync, (hm >= HD + HF && hm < HD + HF + HS) ? 0 : 1);
      check("vsync",        vga.vsync, (vm >= VD + VF && vm < VD + VF + VS) ? 0 : 1);
      check("frame_start",  vga.frame_start, (hm == 0 && vm == 0) ? 1 : 0);
      check("vblank_start", vga.vblank_start, (hm == 0 && vm == VD) ? 1 : 0);
      check("camera_y",     vga.camera_y, cam_exp);
      check("p_tick_low",   vga.p_tick, 0);
`ifdef VGA_FRAME_CNT_EN
      check("frame_cnt",    frame_cnt, fc_exp);
`endif
      if (hm == 0 && vm == 0) begin
        if (last_fs >= 0) check("frame_period", clk_cnt - last_fs, HT * VT * CLK_DIV);
        last_fs = clk_cnt;
      end

      // camera row changes mid-frame must not reach camera_y before vblank
      if (hm == 0) begin
        if (frame == 0 && vm == 1) vga.camera_y_in = 5'd3;
        if (frame == 0 && vm == 2) vga.camera_y_in = 5'd7;
        if (frame == 1 && vm == 1) vga.camera_y_in = 5'd9;
        if (frame == 1 && vm == 5) vga.camera_y_in = 5'd12;
      end

      // outputs hold until the next p_tick, which is CLK_DIV-1 cycles away
      waited = 0;
      while (waited < 16) begin
        @(negedge clk);
        clk_cnt++;
        waited++;
        if (vga.p_tick === 1'b1) break;
        check("x_stable",    vga.x, hm);
        check("pulse_width", {31'd0, vga.frame_start | vga.vblank_start}, 0);
      end
      check("tick_spacing", waited, CLK_DIV - 1);
    end

    // ---- asynchronous reset inside hsync ----
    found = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (vga.x == SW'(HD + HF)) begin
        found = 1;
        break;
      end
    end
    check("reach_hsync", found, 1);
    check("hsync_active", vga.hsync, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_hsync",    vga.hsync, 1);
    check("arst_x",        vga.x, 0);
    check("arst_y",        vga.y, 0);
    check("arst_p_tick",   vga.p_tick, 0);
    check("arst_camera_y", vga.camera_y, 0);
`ifdef VGA_FRAME_CNT_EN
    check("arst_frame_cnt", frame_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("resume_x0",     vga.x, 0);
    check("resume_p_tick", vga.p_tick, 1);
    @(negedge clk);
    check("resume_x1",     vga.x, 1);
    check("resume_y0",     vga.y, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
